// File: rtl/ram_bus_master_pkg.sv
// ram_bus_master_pkg
//   Shared definitions for the RAM bus initiator: default geometry of the
//   8x8 RAM array and the controller state encoding.
package ram_bus_master_pkg;

  localparam int unsigned RAM_AW = 3;  // address width, RAM depth = 2**RAM_AW
  localparam int unsigned RAM_DW = 8;  // data width

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR       = 2'd1,
    RD_ISSUE = 2'd2,
    RD_WAIT  = 2'd3
  } state_e;

endpackage

// File: rtl/ram_bus_master_if.sv
// ram_bus_master_if
//   Bundles the host-side command / write-stream / read-stream channels and
//   the RAM-side bus (cs/rw/addr/d_in/d_out) of the RAM bus initiator.
//   modport master : the initiator (drives ready/read data/RAM bus)
//   modport slave  : host logic plus the RAM (drives commands/write data/d_out)
//
// Handshake rule for all three streams (cmd, wr, rd): a transfer happens on a
// rising clk edge where valid and ready are both 1. A source holds valid and
// its payload stable until that edge; ready may depend only on the sink state.
interface ram_bus_master_if #(
  parameter int unsigned AW = 3,
  parameter int unsigned DW = 8
);

  // command channel
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_len;
  // write-data stream
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  // read-data stream
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  // status
  logic          busy;
  // RAM bus
  logic          mem_cs;
  logic          mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_valid, wr_data,
    input  rd_ready,
    input  mem_rdata,
    output cmd_ready, wr_ready,
    output rd_valid, rd_data, rd_last,
    output busy,
    output mem_cs, mem_rw, mem_addr, mem_wdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_valid, wr_data,
    output rd_ready,
    output mem_rdata,
    input  cmd_ready, wr_ready,
    input  rd_valid, rd_data, rd_last,
    input  busy,
    input  mem_cs, mem_rw, mem_addr, mem_wdata
  );

endinterface

// File: rtl/ram_bus_master.sv
// ram_bus_master
//   Burst initiator for the 8x8 RAM array. A command (start address, beats-1,
//   direction) is accepted in IDLE; writes then take one beat per cycle from
//   the write stream and issue one RAM write cycle each; reads issue one RAM
//   read cycle, capture d_out, and present it on the read stream until it is
//   consumed (one beat per two cycles at full rate). Addresses wrap modulo
//   2**AW.
// Ports
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset
//   bus     : ram_bus_master_if.master (cmd / wr / rd streams, busy, RAM bus)
//   state_o : current controller state, for observation
module ram_bus_master
  import ram_bus_master_pkg::*;
#(
  parameter int unsigned AW = RAM_AW,
  parameter int unsigned DW = RAM_DW
) (
  input  logic              clk,
  input  logic              rst,
  ram_bus_master_if.master  bus,
  output state_e            state_o
);

  state_e        state_q;
  logic [AW-1:0] ptr_q;       // address of the current beat
  logic [AW-1:0] cnt_q;       // beats remaining after the current one
  logic          mem_cs_q;
  logic          mem_rw_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] rd_data_q;
  logic          rd_valid_q;
  logic          rd_last_q;

  // Stream readiness and status follow the state directly.
  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.wr_ready  = (state_q == WR);
  assign bus.busy      = (state_q != IDLE);

  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_last   = rd_last_q;
  assign bus.mem_cs    = mem_cs_q;
  assign bus.mem_rw    = mem_rw_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  assign state_o = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Dropping cs here guarantees an interrupted burst leaves no partial
      // RAM cycle behind.
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      mem_cs_q    <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Ends the final write cycle of a preceding burst, while a new
          // command can already be accepted in this same cycle.
          mem_cs_q <= 1'b0;
          if (bus.cmd_valid) begin
            ptr_q <= bus.cmd_addr;
            cnt_q <= bus.cmd_len;
            if (bus.cmd_write) begin
              state_q <= WR;
            end else begin
              mem_cs_q   <= 1'b1;
              mem_rw_q   <= 1'b0;
              mem_addr_q <= bus.cmd_addr;
              state_q    <= RD_ISSUE;
            end
          end
        end

        WR: begin
          if (bus.wr_valid) begin
            // One RAM write cycle per accepted beat.
            mem_cs_q    <= 1'b1;
            mem_rw_q    <= 1'b1;
            mem_addr_q  <= ptr_q;
            mem_wdata_q <= bus.wr_data;
            ptr_q       <= ptr_q + AW'(1);
            cnt_q       <= cnt_q - AW'(1);
            if (cnt_q == '0) begin
              state_q <= IDLE;
            end
          end else begin
            mem_cs_q <= 1'b0;
          end
        end

        RD_ISSUE: begin
          // cs=1, rw=0 has been on the bus for this whole cycle, so d_out is
          // valid; this is the only place d_out is sampled.
          rd_data_q  <= bus.mem_rdata;
          rd_valid_q <= 1'b1;
          rd_last_q  <= (cnt_q == '0);
          mem_cs_q   <= 1'b0;
          state_q    <= RD_WAIT;
        end

        RD_WAIT: begin
          if (bus.rd_ready) begin
            rd_valid_q <= 1'b0;
            if (cnt_q == '0) begin
              state_q <= IDLE;
            end else begin
              ptr_q      <= ptr_q + AW'(1);
              cnt_q      <= cnt_q - AW'(1);
              mem_cs_q   <= 1'b1;
              mem_rw_q   <= 1'b0;
              mem_addr_q <= ptr_q + AW'(1);
              state_q    <= RD_ISSUE;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bus_master.sv
// tb_ram_bus_master
//   Drives ram_bus_master against a behavioural 8x8 RAM and checks the
//   command, write and read streams and the RAM bus cycles it generates.
module tb_ram_bus_master;
  import ram_bus_master_pkg::*;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_e state;

  always #5 clk = ~clk;

  ram_bus_master_if #(.AW(3), .DW(8)) bus ();

  ram_bus_master #(.AW(3), .DW(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state)
  );

  // Behavioural RAM: write on the clock edge, combinational read. When not
  // selected it returns a marker value so any capture off-cycle is visible.
  logic [7:0] ram [8];
  always @(posedge clk) begin
    if (bus.mem_cs && bus.mem_rw) ram[bus.mem_addr] <= bus.mem_wdata;
  end
  assign bus.mem_rdata = (bus.mem_cs && !bus.mem_rw) ? ram[bus.mem_addr] : 8'hEE;

  // ---------------- scoreboard ----------------
  int         errors = 0;
  int         checks = 0;
  logic [7:0] model_mem [8];
  logic [7:0] exp_q [$];      // expected read beats
  logic [2:0] wa_q [$];       // expected RAM write addresses
  logic [7:0] wd_q [$];       // expected RAM write data
  int         exp_writes = 0;
  int         got_writes = 0;
  logic       hold_mon = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RAM write-cycle monitor: every cs&rw cycle must match the next expected write.
  always @(negedge clk) begin
    if (!rst && bus.mem_cs && bus.mem_rw) begin
      got_writes++;
      check("wr_expected", 32'(wa_q.size() > 0), 32'd1);
      if (wa_q.size() > 0) begin
        check("wr_addr", 32'(bus.mem_addr), 32'(wa_q.pop_front()));
        check("wr_data", 32'(bus.mem_wdata), 32'(wd_q.pop_front()));
      end
    end
  end

  // A command held while busy must not be accepted.
  always @(negedge clk) begin
    if (hold_mon && bus.busy) check("cmd_ready_busy", 32'(bus.cmd_ready), 32'd0);
  end

  // ---------------- driver tasks ----------------
  task automatic do_cmd(input logic w, input logic [2:0] a, input logic [2:0] l,
                        output int waited);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    waited = 0;
    while (!bus.cmd_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wr_beats(input logic [2:0] addr, input logic [2:0] len,
                          input logic [63:0] data, input int gap);
    logic [2:0] a;
    logic [7:0] d;
    int         n;
    for (int i = 0; i <= int'(len); i++) begin
      a = addr + 3'(i);
      d = data[8*i +: 8];
      model_mem[a] = d;
      wa_q.push_back(a);
      wd_q.push_back(d);
      exp_writes++;
      bus.wr_valid = 1'b1;
      bus.wr_data  = d;
      n = 0;
      while (!bus.wr_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("wr_ready_wait", 32'(bus.wr_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      bus.wr_valid = 1'b0;
      if (i < int'(len)) begin
        repeat (gap) begin
          @(negedge clk);
          check("gap_mem_cs", 32'(bus.mem_cs), 32'd0);
        end
      end
    end
  endtask

  // Consumes 'take' beats of a read burst of len+1 beats, holding rd_ready
  // low for 'stall' cycles before each beat.
  task automatic rd_burst(input logic [2:0] addr, input logic [2:0] len,
                          input int stall, input int take);
    logic [7:0] e;
    int         n;
    for (int i = 0; i <= int'(len); i++) exp_q.push_back(model_mem[addr + 3'(i)]);
    for (int i = 0; i < take; i++) begin
      n = 0;
      while (!bus.rd_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("rd_valid_wait", 32'(bus.rd_valid), 32'd1);
      e = exp_q[0];
      repeat (stall) begin
        @(negedge clk);
        check("stall_rd_data", 32'(bus.rd_data), 32'(e));
        check("stall_rd_valid", 32'(bus.rd_valid), 32'd1);
        check("stall_mem_cs", 32'(bus.mem_cs), 32'd0);
      end
      e = exp_q.pop_front();
      check("rd_data", 32'(bus.rd_data), 32'(e));
      check("rd_last", 32'(bus.rd_last), 32'(i == int'(len)));
      bus.rd_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.rd_ready = 1'b0;
    end
    if (take == int'(len) + 1) check("rd_done_busy", 32'(bus.busy), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [2:0]  len;
    int          gap;
    int          stall;
    logic [63:0] data;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;

    vecs[0] = '{1'b1, 3'd6, 3'd3, 0, 0, 64'h00000000_44332211};
    vecs[1] = '{1'b0, 3'd6, 3'd3, 0, 0, 64'h0};
    vecs[2] = '{1'b1, 3'd2, 3'd1, 2, 0, {32'h0, $urandom()}};
    vecs[3] = '{1'b0, 3'd2, 3'd1, 0, 5, 64'h0};
    vecs[4] = '{1'b1, 3'd0, 3'd7, 0, 0, {$urandom(), $urandom()}};
    vecs[5] = '{1'b0, 3'd0, 3'd7, 0, 0, 64'h0};
    vecs[6] = '{1'b0, 3'd3, 3'd2, 0, 2, 64'h0};
    vecs[7] = '{1'b1, 3'd7, 3'd0, 0, 0, {56'h0, 8'($urandom_range(0, 255))}};
    vecs[8] = '{1'b0, 3'd7, 3'd0, 0, 1, 64'h0};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_cs", 32'(bus.mem_cs), 32'd0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rd_data", 32'(bus.rd_data), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_state", 32'(state), 32'(IDLE));
    rst = 1'b0;
    check("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // single-beat write then read, with read latency
    do_cmd(1'b1, 3'd5, 3'd0, w);
    wr_beats(3'd5, 3'd0, 64'hF0, 0);
    do_cmd(1'b0, 3'd5, 3'd0, w);
    check("lat_rd_valid_e1", 32'(bus.rd_valid), 32'd0);
    check("lat_mem_cs", 32'(bus.mem_cs), 32'd1);
    check("lat_mem_rw", 32'(bus.mem_rw), 32'd0);
    check("lat_mem_addr", 32'(bus.mem_addr), 32'd5);
    @(negedge clk);
    check("lat_rd_valid_e2", 32'(bus.rd_valid), 32'd1);
    check("lat_rd_data", 32'(bus.rd_data), 32'hF0);
    check("lat_rd_last", 32'(bus.rd_last), 32'd1);
    rd_burst(3'd5, 3'd0, 0, 1);

    // table-driven bursts
    for (int v = 0; v < 9; v++) begin
      do_cmd(vecs[v].wr, vecs[v].addr, vecs[v].len, w);
      if (vecs[v].wr) wr_beats(vecs[v].addr, vecs[v].len, vecs[v].data, vecs[v].gap);
      else            rd_burst(vecs[v].addr, vecs[v].len, vecs[v].stall, int'(vecs[v].len) + 1);
    end

    // reset after the second beat of a four-beat read
    do_cmd(1'b0, 3'd0, 3'd3, w);
    rd_burst(3'd0, 3'd3, 0, 2);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_state", 32'(state), 32'(IDLE));
    check("mid_rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("mid_rst_mem_cs", 32'(bus.mem_cs), 32'd0);
    check("mid_rst_rd_data", 32'(bus.rd_data), 32'd0);
    exp_q.delete();
    rst = 1'b0;
    do_cmd(1'b0, 3'd0, 3'd0, w);
    check("post_rst_wait", 32'(w), 32'd0);
    rd_burst(3'd0, 3'd0, 0, 1);

    // command held while a write burst runs
    do_cmd(1'b1, 3'd4, 3'd2, w);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 3'd4;
    bus.cmd_len   = 3'd2;
    hold_mon = 1'b1;
    wr_beats(3'd4, 3'd2, 64'h00000000_00C3B2A1, 0);
    check("hold_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("hold_state", 32'(state), 32'(IDLE));
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    hold_mon = 1'b0;
    check("hold_accept_state", 32'(state), 32'(RD_ISSUE));
    rd_burst(3'd4, 3'd2, 0, 3);

    repeat (3) @(negedge clk);
    check("total_writes", 32'(got_writes), 32'(exp_writes));
    check("wr_q_empty", 32'(wa_q.size()), 32'd0);
    check("rd_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
